// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned DefaultWidth = 8;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: conditional accumulate, then shift both operands.
module seq_mult_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    always_comb begin
        acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential WIDTH x WIDTH multiplier with valid/ready handshakes on both sides.
// Signed mode is compiled in when SEQ_MULT_SIGNED_EN is defined.
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               op_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [2*WIDTH-1:0] acc_nx, mcand_nx;
    logic [WIDTH-1:0]   mplier_nx;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] result;

`ifdef SEQ_MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   OneW  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] OneP  = (2*WIDTH)'(1);
    logic sign_q, sign_d;

    // Operands become magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        a_mag  = (op_signed && a[WIDTH-1]) ? (~a + OneW) : a;
        b_mag  = (op_signed && b[WIDTH-1]) ? (~b + OneW) : b;
        result = sign_q ? (~acc_nx + OneP) : acc_nx;
    end
`else
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        result = acc_nx;
    end
`endif

    seq_mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .mplier_i(mplier_q),
        .acc_o   (acc_nx),
        .mcand_o (mcand_nx),
        .mplier_o(mplier_nx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_nx;
                mplier_d = mplier_nx;
                cnt_d    = cnt_q + CntOne;
                if (cnt_q == LastIter) begin
                    product_d = result;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StRun) || (state_q == StDone);
        product   = product_q;
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: WIDTH=8 and WIDTH=4 instances on one clock.
module tb_seq_mult_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;
`ifdef SEQ_MULT_SIGNED_EN
    logic        op_signed8 = 1'b0;
    logic        op_signed4 = 1'b0;
`endif

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_pass = 0;

    seq_mult_unit #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .a        (a8),
        .b        (b8),
`ifdef SEQ_MULT_SIGNED_EN
        .op_signed(op_signed8),
`endif
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .product  (product8),
        .busy     (busy8)
    );

    seq_mult_unit #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .a        (a4),
        .b        (b4),
`ifdef SEQ_MULT_SIGNED_EN
        .op_signed(op_signed4),
`endif
        .out_valid(out_valid4),
        .out_ready(out_ready4),
        .product  (product4),
        .busy     (busy4)
    );

    // Runs one WIDTH=8 op with out_ready held high; called #1 after a rising edge in IDLE.
    // lat counts edges from the in_valid cycle until out_valid is seen (-1 on timeout).
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       output int lat, output logic [15:0] prod,
                       output bit ready_low_ok, output bit ready_after);
        a8 = av;
        b8 = bv;
`ifdef SEQ_MULT_SIGNED_EN
        op_signed8 = sv;
`else
        if (sv) $display("note: signed op requested in unsigned build");
`endif
        out_ready8 = 1'b1;
        in_valid8 = 1'b1;
        ready_low_ok = in_ready8;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            if (in_ready8) ready_low_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid8) lat = -1;
        if (in_ready8) ready_low_ok = 1'b0;
        prod = product8;
        @(posedge clk); #1;
        ready_after = in_ready8 && !out_valid8;
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                       output int lat, output logic [7:0] prod);
        a4 = av;
        b4 = bv;
        out_ready4 = 1'b1;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid4) lat = -1;
        prod = product4;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready8, out_valid8, busy8} !== 3'b100)
            $display("FAIL reset_flags8: got %b want 100", {in_ready8, out_valid8, busy8});
        else n_pass++;
        n_checks++;
        if (product8 !== 16'h0000) $display("FAIL reset_prod8: got %h want 0000", product8);
        else n_pass++;
        n_checks++;
        if ({in_ready4, out_valid4, busy4, product4} !== {3'b100, 8'h00})
            $display("FAIL reset_w4: got %b/%h want 100/00",
                     {in_ready4, out_valid4, busy4}, product4);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] p;
        bit rlo, ra;
        op8(8'd13, 8'd11, 1'b0, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h008F) $display("FAIL basic_prod: got %h want 008f", p);
        else n_pass++;
        n_checks++;
        if (lat !== 9) $display("FAIL basic_latency: got %0d want 9", lat);
        else n_pass++;
        n_checks++;
        if (rlo !== 1'b1) $display("FAIL basic_in_ready_low: got %b want 1", rlo);
        else n_pass++;
        n_checks++;
        if (ra !== 1'b1) $display("FAIL basic_in_ready_after: got %b want 1", ra);
        else n_pass++;
    endtask

    task automatic test_extremes();
        int lat;
        logic [15:0] p;
        bit rlo, ra;
        op8(8'hFF, 8'hFF, 1'b0, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'hFE01) $display("FAIL max_prod: got %h want fe01", p);
        else n_pass++;
        op8(8'h00, 8'h09, 1'b0, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h0000) $display("FAIL zero_prod: got %h want 0000", p);
        else n_pass++;
        n_checks++;
        if (lat !== 9) $display("FAIL zero_latency: got %0d want 9", lat);
        else n_pass++;
        op8(8'hFD, 8'h05, 1'b0, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h04F1) $display("FAIL unsigned_fd_prod: got %h want 04f1", p);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int n;
        a8 = 8'd5;
        b8 = 8'd3;
        out_ready8 = 1'b0;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (out_valid8 !== 1'b1) $display("FAIL bp_out_valid_timeout: got %b want 1", out_valid8);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'hAA;
            b8 = 8'h55;
            in_valid8 = (i % 2 == 0) && (i < 4);
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid8, in_ready8, busy8, product8} !== {3'b101, 16'h000F})
                $display("FAIL bp_hold_%0d: got %b/%h want 101/000f", i,
                         {out_valid8, in_ready8, busy8}, product8);
            else n_pass++;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready8, out_valid8, busy8, product8} !== {3'b100, 16'h000F})
            $display("FAIL bp_release: got %b/%h want 100/000f",
                     {in_ready8, out_valid8, busy8}, product8);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [15:0] p;
        bit rlo, ra;
        a8 = 8'd200;
        b8 = 8'd100;
        out_ready8 = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid8, in_ready8, busy8, product8} !== {3'b010, 16'h0000})
            $display("FAIL midrst_state: got %b/%h want 010/0000",
                     {out_valid8, in_ready8, busy8}, product8);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'd7, 8'd6, 1'b0, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h002A) $display("FAIL midrst_next_prod: got %h want 002a", p);
        else n_pass++;
        n_checks++;
        if (lat !== 9) $display("FAIL midrst_next_latency: got %0d want 9", lat);
        else n_pass++;
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        int lat;
        logic [15:0] p;
        bit rlo, ra;
        op8(8'hFD, 8'h05, 1'b1, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'hFFF1) $display("FAIL signed_neg: got %h want fff1", p);
        else n_pass++;
        n_checks++;
        if (lat !== 9) $display("FAIL signed_latency: got %0d want 9", lat);
        else n_pass++;
        op8(8'hFD, 8'h05, 1'b0, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h04F1) $display("FAIL signed_mode_off: got %h want 04f1", p);
        else n_pass++;
        op8(8'h80, 8'h80, 1'b1, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h4000) $display("FAIL signed_min_sq: got %h want 4000", p);
        else n_pass++;
        op8(8'hFD, 8'hFB, 1'b1, lat, p, rlo, ra);
        n_checks++;
        if (p !== 16'h000F) $display("FAIL signed_neg_neg: got %h want 000f", p);
        else n_pass++;
    endtask
`endif

    task automatic test_width4();
        int lat;
        logic [7:0] p;
        logic [7:0] want;
        op4(4'd15, 4'd15, lat, p);
        n_checks++;
        if (p !== 8'hE1) $display("FAIL w4_max_prod: got %h want e1", p);
        else n_pass++;
        n_checks++;
        if (lat !== 5) $display("FAIL w4_latency: got %0d want 5", lat);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                want = 8'(i * j);
                op4(4'(i), 4'(j), lat, p);
                n_checks++;
                if (p !== want || lat !== 5)
                    $display("FAIL w4_sweep %0d*%0d: got %h lat %0d want %h lat 5",
                             i, j, p, lat, want);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_mid_op();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        test_width4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
